// File: rtl/pnseq63_tx_if.sv
// pnseq63_tx_if: sample stream carrying BPSK PN chips to the axi_wrapper.
// master drives data/last/valid, slave returns ready.
interface pnseq63_tx_if;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;

  modport master (
    output o_tdata,
    output o_tlast,
    output o_tvalid,
    input  o_tready
  );

  modport slave (
    input  o_tdata,
    input  o_tlast,
    input  o_tvalid,
    output o_tready
  );
endinterface

// File: rtl/pnseq63_tx.sv
// pnseq63_tx: channel-sounder transmit engine. Emits a repeating 63-chip
// PN sequence as BPSK {I,Q} samples, packetized with tlast, from settings
// registers. Optional guard interval between periods is built when the
// macro PNSEQ_TX_GUARD_EN is defined (settings address 132, readback 5).
module pnseq63_tx #(
  parameter logic [7:0] SR_MODE         = 8'd128,
  parameter logic [7:0] SR_PNSEQ_PARAMS = 8'd129,
  parameter logic [7:0] SR_AMPL         = 8'd130,
  parameter logic [7:0] SR_BURST_PARAMS = 8'd131
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [7:0]  rb_addr,
  output logic [63:0] rb_data,
  pnseq63_tx_if.master m_axis
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        mode_q, mode_d;
  logic [5:0]  seed_q, seed_d;
  logic [5:0]  taps_q, taps_d;
  logic [14:0] ampl_q, ampl_d;
  logic [15:0] pkt_len_q, pkt_len_d;
  logic [15:0] num_periods_q, num_periods_d;

  // Shadows used by the running burst; only refreshed on IDLE->RUN.
  logic [5:0]  act_seed_q, act_seed_d;
  logic [5:0]  act_taps_q, act_taps_d;
  logic [14:0] act_ampl_q, act_ampl_d;
  logic [15:0] act_pkt_len_q, act_pkt_len_d;
  logic [15:0] act_num_periods_q, act_num_periods_d;

  // Generator state describes the beat currently held in the output register.
  logic [5:0]  lfsr_q, lfsr_d;
  logic [5:0]  chip_cnt_q, chip_cnt_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] periods_sent_q, periods_sent_d;

  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic [31:0] tdata_q, tdata_d;
  logic [63:0] rb_q, rb_d;

`ifdef PNSEQ_TX_GUARD_EN
  logic [15:0] guard_len_q, guard_len_d;
  logic [15:0] act_guard_len_q, act_guard_len_d;
  logic [15:0] guard_cnt_q, guard_cnt_d;
  logic        in_guard_q, in_guard_d;
`endif

  // Next-beat temporaries
  logic [5:0]  lfsr_nxt;
  logic [5:0]  chip_nxt;
  logic [15:0] pkt_nxt;
  logic        gap_nxt;

  logic        fb;
  logic        accept;
  logic        last_chip;
  logic        final_beat;
  logic        stopping;

  assign fb         = ^(lfsr_q & act_taps_q);
  assign accept     = tvalid_q && m_axis.o_tready;
  assign last_chip  = (chip_cnt_q == 6'd62);
  assign final_beat = (act_num_periods_q != 16'd0) && last_chip &&
                      (periods_sent_q == ({16'd0, act_num_periods_q} - 32'd1));
  // A tlast beat ends the burst once enable has been withdrawn.
  assign stopping   = (state_q == S_STOP) || ((state_q == S_RUN) && !mode_q);

  assign m_axis.o_tdata  = tdata_q;
  assign m_axis.o_tlast  = tlast_q;
  assign m_axis.o_tvalid = tvalid_q;
  assign rb_data         = rb_q;

  // BPSK map: chip 1 -> +ampl, chip 0 -> -ampl on I; Q is zero.
  function automatic logic [31:0] map_chip(input logic chip, input logic [14:0] ampl);
    logic [15:0] mag;
    mag = {1'b0, ampl};
    return chip ? {mag, 16'h0000} : {(~mag + 16'd1), 16'h0000};
  endfunction

  // Settings writes, state machine and next output beat
  always_comb begin
    state_d           = state_q;
    mode_d            = mode_q;
    seed_d            = seed_q;
    taps_d            = taps_q;
    ampl_d            = ampl_q;
    pkt_len_d         = pkt_len_q;
    num_periods_d     = num_periods_q;
    act_seed_d        = act_seed_q;
    act_taps_d        = act_taps_q;
    act_ampl_d        = act_ampl_q;
    act_pkt_len_d     = act_pkt_len_q;
    act_num_periods_d = act_num_periods_q;
    lfsr_d            = lfsr_q;
    chip_cnt_d        = chip_cnt_q;
    pkt_cnt_d         = pkt_cnt_q;
    periods_sent_d    = periods_sent_q;
    tvalid_d          = tvalid_q;
    tlast_d           = tlast_q;
    tdata_d           = tdata_q;
    lfsr_nxt          = lfsr_q;
    chip_nxt          = chip_cnt_q;
    pkt_nxt           = 16'd0;
    gap_nxt           = 1'b0;
`ifdef PNSEQ_TX_GUARD_EN
    guard_len_d       = guard_len_q;
    act_guard_len_d   = act_guard_len_q;
    guard_cnt_d       = guard_cnt_q;
    in_guard_d        = in_guard_q;
`endif

    if (set_stb) begin
      case (set_addr)
        SR_MODE:         mode_d = set_data[0];
        SR_PNSEQ_PARAMS: begin
          seed_d = set_data[5:0];
          taps_d = set_data[11:6];
        end
        SR_AMPL:         ampl_d = set_data[14:0];
        SR_BURST_PARAMS: begin
          pkt_len_d     = set_data[15:0];
          num_periods_d = set_data[31:16];
        end
`ifdef PNSEQ_TX_GUARD_EN
        SR_BURST_PARAMS + 8'd1: guard_len_d = set_data[15:0];
`endif
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        // Looking at mode_d lets the first beat appear the cycle after the write.
        if (mode_d) begin
          state_d           = S_RUN;
          act_seed_d        = (seed_d == 6'd0) ? 6'd1 : seed_d;
          act_taps_d        = taps_d;
          act_ampl_d        = ampl_d;
          act_pkt_len_d     = (pkt_len_d == 16'd0) ? 16'd63 : pkt_len_d;
          act_num_periods_d = num_periods_d;
          lfsr_d            = act_seed_d;
          chip_cnt_d        = 6'd0;
          pkt_cnt_d         = 16'd0;
          periods_sent_d    = 32'd0;
          tvalid_d          = 1'b1;
          tdata_d           = map_chip(act_seed_d[0], act_ampl_d);
          tlast_d           = (act_pkt_len_d == 16'd1);
`ifdef PNSEQ_TX_GUARD_EN
          act_guard_len_d   = guard_len_d;
          guard_cnt_d       = 16'd0;
          in_guard_d        = 1'b0;
`endif
        end
      end

      S_RUN, S_STOP: begin
        if ((state_q == S_RUN) && !mode_q) begin
          state_d = S_STOP;
        end
        if (accept) begin
          if (last_chip) begin
            periods_sent_d = periods_sent_q + 32'd1;
          end
          if (final_beat || (tlast_q && stopping)) begin
            state_d  = S_IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = 32'd0;
            if (final_beat) begin
              mode_d = 1'b0;
            end
          end else begin
`ifdef PNSEQ_TX_GUARD_EN
            if (in_guard_q) begin
              if (guard_cnt_q == act_guard_len_q - 16'd1) begin
                in_guard_d = 1'b0;
              end else begin
                guard_cnt_d = guard_cnt_q + 16'd1;
                gap_nxt     = 1'b1;
              end
            end else
`endif
            if (last_chip) begin
              // Reload keeps every period chip-aligned whatever the taps.
              chip_nxt = 6'd0;
              lfsr_nxt = act_seed_q;
`ifdef PNSEQ_TX_GUARD_EN
              if (act_guard_len_q != 16'd0) begin
                in_guard_d  = 1'b1;
                guard_cnt_d = 16'd0;
                gap_nxt     = 1'b1;
              end
`endif
            end else begin
              chip_nxt = chip_cnt_q + 6'd1;
              lfsr_nxt = {fb, lfsr_q[5:1]};
            end
            pkt_nxt    = tlast_q ? 16'd0 : (pkt_cnt_q + 16'd1);
            lfsr_d     = lfsr_nxt;
            chip_cnt_d = chip_nxt;
            pkt_cnt_d  = pkt_nxt;
            tdata_d    = gap_nxt ? 32'd0 : map_chip(lfsr_nxt[0], act_ampl_q);
            tlast_d    = (pkt_nxt == act_pkt_len_q - 16'd1) ||
                         (!gap_nxt && (act_num_periods_q != 16'd0) && (chip_nxt == 6'd62) &&
                          (periods_sent_d == ({16'd0, act_num_periods_q} - 32'd1)));
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Readback mux, registered below
  always_comb begin
    rb_d = 64'd0;
    case (rb_addr)
      8'd0: rb_d = {63'd0, mode_q};
      8'd1: rb_d = {52'd0, taps_q, seed_q};
      8'd2: rb_d = {49'd0, ampl_q};
      8'd3: rb_d = {32'd0, num_periods_q, pkt_len_q};
      8'd4: rb_d = {periods_sent_q, 30'd0, state_q};
`ifdef PNSEQ_TX_GUARD_EN
      8'd5: rb_d = {48'd0, guard_len_q};
`endif
      default: ;
    endcase
  end

  // State, settings and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_IDLE;
      mode_q            <= 1'b0;
      seed_q            <= 6'h3F;
      taps_q            <= 6'h03;
      ampl_q            <= 15'h2000;
      pkt_len_q         <= 16'd63;
      num_periods_q     <= 16'd0;
      act_seed_q        <= 6'h3F;
      act_taps_q        <= 6'h03;
      act_ampl_q        <= 15'h2000;
      act_pkt_len_q     <= 16'd63;
      act_num_periods_q <= 16'd0;
      lfsr_q            <= 6'h3F;
      chip_cnt_q        <= 6'd0;
      pkt_cnt_q         <= 16'd0;
      periods_sent_q    <= 32'd0;
      tvalid_q          <= 1'b0;
      tlast_q           <= 1'b0;
      tdata_q           <= 32'd0;
      rb_q              <= 64'd0;
`ifdef PNSEQ_TX_GUARD_EN
      guard_len_q       <= 16'd0;
      act_guard_len_q   <= 16'd0;
      guard_cnt_q       <= 16'd0;
      in_guard_q        <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      mode_q            <= mode_d;
      seed_q            <= seed_d;
      taps_q            <= taps_d;
      ampl_q            <= ampl_d;
      pkt_len_q         <= pkt_len_d;
      num_periods_q     <= num_periods_d;
      act_seed_q        <= act_seed_d;
      act_taps_q        <= act_taps_d;
      act_ampl_q        <= act_ampl_d;
      act_pkt_len_q     <= act_pkt_len_d;
      act_num_periods_q <= act_num_periods_d;
      lfsr_q            <= lfsr_d;
      chip_cnt_q        <= chip_cnt_d;
      pkt_cnt_q         <= pkt_cnt_d;
      periods_sent_q    <= periods_sent_d;
      tvalid_q          <= tvalid_d;
      tlast_q           <= tlast_d;
      tdata_q           <= tdata_d;
      rb_q              <= rb_d;
`ifdef PNSEQ_TX_GUARD_EN
      guard_len_q       <= guard_len_d;
      act_guard_len_q   <= act_guard_len_d;
      guard_cnt_q       <= guard_cnt_d;
      in_guard_q        <= in_guard_d;
`endif
    end
  end

endmodule

// File: tb/tb_pnseq63_tx.sv
// tb_pnseq63_tx: directed tests for pnseq63_tx, one task per scenario.
`timescale 1ns/1ps
module tb_pnseq63_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = 8'd0;
  logic [31:0] set_data = 32'd0;
  logic [7:0]  rb_addr = 8'd0;
  logic [63:0] rb_data;

  pnseq63_tx_if axis ();

  pnseq63_tx dut (
    .clk      (clk),
    .rst      (rst),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data),
    .rb_addr  (rb_addr),
    .rb_data  (rb_data),
    .m_axis   (axis)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] cap_data [0:1023];
  logic        cap_last [0:1023];
  int          cap_n;
  int          stall_bad;
  bit          timed_out;
  logic [31:0] exp_data [0:1023];
  logic        exp_last [0:1023];

  // Expected beats: LFSR s_next={^(s&taps),s[5:1]}, reload every 63 chips.
  task automatic build_expected(input logic [5:0] seed, input logic [5:0] taps,
                                input logic [14:0] ampl, input int total, input int pkt_len);
    logic [5:0]  s;
    logic [15:0] mag;
    logic [15:0] neg;
    s   = seed;
    mag = {1'b0, ampl};
    neg = ~mag + 16'd1;
    for (int k = 0; k < total; k++) begin
      exp_data[k] = s[0] ? {mag, 16'h0000} : {neg, 16'h0000};
      exp_last[k] = (((k + 1) % pkt_len) == 0) || ((k + 1) == total);
      if ((k % 63) == 62) s = seed;
      else s = {^(s & taps), s[5:1]};
    end
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    @(posedge clk);
    #1;
    set_stb = 1'b0;
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [63:0] d);
    @(negedge clk);
    rb_addr = a;
    @(negedge clk);
    d = rb_data;
  endtask

  // Captures accepted beats until o_tvalid falls; optionally writes a
  // register in the cycle the wr_beat-th beat is accepted.
  task automatic collect(input int max_cycles, input bit rand_ready, input int wr_beat,
                         input logic [7:0] wr_a, input logic [31:0] wr_d);
    logic [31:0] prev_data;
    logic        prev_last;
    bit          stalled;
    bit          started;
    cap_n = 0; stall_bad = 0; timed_out = 1'b0;
    stalled = 1'b0; started = 1'b0;
    prev_data = 32'd0; prev_last = 1'b0;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      @(negedge clk);
      set_stb = 1'b0;
      if (stalled && (axis.o_tvalid !== 1'b1 || axis.o_tdata !== prev_data ||
                      axis.o_tlast !== prev_last)) stall_bad++;
      if (started && axis.o_tvalid !== 1'b1) begin
        axis.o_tready = 1'b1;
        return;
      end
      if (axis.o_tvalid === 1'b1) started = 1'b1;
      axis.o_tready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (axis.o_tvalid === 1'b1 && axis.o_tready) begin
        cap_data[cap_n] = axis.o_tdata;
        cap_last[cap_n] = axis.o_tlast;
        cap_n++;
        stalled = 1'b0;
        if (cap_n == wr_beat) begin
          set_stb = 1'b1; set_addr = wr_a; set_data = wr_d;
        end
      end else if (axis.o_tvalid === 1'b1) begin
        stalled = 1'b1; prev_data = axis.o_tdata; prev_last = axis.o_tlast;
      end else begin
        stalled = 1'b0;
      end
    end
    timed_out = 1'b1;
    axis.o_tready = 1'b1;
  endtask

  task automatic test_reset();
    logic [63:0] d;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (axis.o_tvalid !== 1'b0 || axis.o_tlast !== 1'b0 || axis.o_tdata !== 32'd0 || rb_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b last=%b data=%h rb=%h, want 0", axis.o_tvalid, axis.o_tlast, axis.o_tdata, rb_data);
    end
    rst = 1'b0;
    read_reg(8'd1, d);
    checks++;
    if (d !== 64'h0FF) begin errors++; $display("FAIL reset_rb1: got %h want 0ff", d); end
    read_reg(8'd2, d);
    checks++;
    if (d !== 64'h2000) begin errors++; $display("FAIL reset_rb2: got %h want 2000", d); end
    read_reg(8'd3, d);
    checks++;
    if (d !== 64'd63) begin errors++; $display("FAIL reset_rb3: got %h want 3f", d); end
    read_reg(8'd4, d);
    checks++;
    if (d !== 64'd0) begin errors++; $display("FAIL reset_rb4: got %h want 0", d); end
    $display("test_reset done");
  endtask

  task automatic test_single_period();
    logic [63:0] d;
    int ones;
    write_reg(8'd131, {16'd1, 16'd63});
    write_reg(8'd128, 32'd1);
    checks++;
    if (axis.o_tvalid !== 1'b1) begin errors++; $display("FAIL start_latency: valid=%b want 1", axis.o_tvalid); end
    collect(400, 1'b0, -1, 8'd0, 32'd0);
    build_expected(6'h3F, 6'h03, 15'h2000, 63, 63);
    checks++;
    if (timed_out || cap_n != 63) begin errors++; $display("FAIL single_count: beats=%0d timeout=%0d want 63", cap_n, timed_out); end
    for (int k = 0; k < 63 && k < cap_n; k++) begin
      checks++;
      if (cap_data[k] !== exp_data[k] || cap_last[k] !== exp_last[k]) begin
        errors++;
        $display("FAIL single_beat%0d: data=%h last=%b want %h %b", k + 1, cap_data[k], cap_last[k], exp_data[k], exp_last[k]);
      end
    end
    // Hand values: six ones from seed 3F, then the first zero chip.
    checks++;
    if (cap_data[0] !== 32'h20000000 || cap_data[5] !== 32'h20000000 || cap_data[6] !== 32'hE0000000) begin
      errors++;
      $display("FAIL single_hand: b1=%h b6=%h b7=%h want 20000000 20000000 e0000000", cap_data[0], cap_data[5], cap_data[6]);
    end
    ones = 0;
    for (int k = 0; k < 63; k++) if (cap_data[k] === 32'h20000000) ones++;
    checks++;
    if (ones != 32) begin errors++; $display("FAIL single_ones: got %0d want 32", ones); end
    read_reg(8'd4, d);
    checks++;
    if (d !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL single_rb4: got %h want 100000000", d); end
    read_reg(8'd0, d);
    checks++;
    if (d !== 64'd0) begin errors++; $display("FAIL single_mode_clear: got %h want 0", d); end
    $display("test_single_period: %0d beats", cap_n);
  endtask

  task automatic test_multi_burst();
    int nlast;
    write_reg(8'd130, 32'h7FFF);
    write_reg(8'd131, {16'd3, 16'd50});
    write_reg(8'd128, 32'd1);
    collect(800, 1'b0, -1, 8'd0, 32'd0);
    build_expected(6'h3F, 6'h03, 15'h7FFF, 189, 50);
    checks++;
    if (timed_out || cap_n != 189) begin errors++; $display("FAIL multi_count: beats=%0d want 189", cap_n); end
    nlast = 0;
    for (int k = 0; k < 189 && k < cap_n; k++) begin
      if (cap_last[k] === 1'b1) nlast++;
      checks++;
      if (cap_data[k] !== exp_data[k] || cap_last[k] !== exp_last[k]) begin
        errors++;
        $display("FAIL multi_beat%0d: data=%h last=%b want %h %b", k + 1, cap_data[k], cap_last[k], exp_data[k], exp_last[k]);
      end
    end
    checks++;
    if (nlast != 4 || cap_last[49] !== 1'b1 || cap_last[99] !== 1'b1 || cap_last[149] !== 1'b1 || cap_last[188] !== 1'b1) begin
      errors++; $display("FAIL multi_tlast: count=%0d want 4 at 50,100,150,189", nlast);
    end
    checks++;
    if (cap_data[0] !== 32'h7FFF0000 || cap_data[6] !== 32'h80010000) begin
      errors++; $display("FAIL multi_ampl: b1=%h b7=%h want 7fff0000 80010000", cap_data[0], cap_data[6]);
    end
    $display("test_multi_burst: %0d beats", cap_n);
  endtask

  task automatic test_backpressure();
    write_reg(8'd130, 32'h2000);
    write_reg(8'd131, {16'd2, 16'd63});
    write_reg(8'd128, 32'd1);
    collect(2000, 1'b1, -1, 8'd0, 32'd0);
    build_expected(6'h3F, 6'h03, 15'h2000, 126, 63);
    checks++;
    if (timed_out || cap_n != 126) begin errors++; $display("FAIL bp_count: beats=%0d want 126", cap_n); end
    checks++;
    if (stall_bad != 0) begin errors++; $display("FAIL bp_stall_hold: changes=%0d want 0", stall_bad); end
    for (int k = 0; k < 126 && k < cap_n; k++) begin
      checks++;
      if (cap_data[k] !== exp_data[k] || cap_last[k] !== exp_last[k]) begin
        errors++;
        $display("FAIL bp_beat%0d: data=%h last=%b want %h %b", k + 1, cap_data[k], cap_last[k], exp_data[k], exp_last[k]);
      end
    end
    $display("test_backpressure: %0d beats", cap_n);
  endtask

  task automatic test_continuous_stop();
    logic [63:0] d;
    write_reg(8'd131, {16'd0, 16'd64});
    write_reg(8'd128, 32'd1);
    collect(600, 1'b0, 100, 8'd128, 32'd0);
    build_expected(6'h3F, 6'h03, 15'h2000, 128, 64);
    checks++;
    if (timed_out || cap_n != 128) begin errors++; $display("FAIL stop_count: beats=%0d want 128", cap_n); end
    for (int k = 0; k < 128 && k < cap_n; k++) begin
      checks++;
      if (cap_data[k] !== exp_data[k] || cap_last[k] !== exp_last[k]) begin
        errors++;
        $display("FAIL stop_beat%0d: data=%h last=%b want %h %b", k + 1, cap_data[k], cap_last[k], exp_data[k], exp_last[k]);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (axis.o_tvalid !== 1'b0) begin errors++; $display("FAIL stop_valid_low: valid=%b want 0", axis.o_tvalid); end
    read_reg(8'd4, d);
    checks++;
    if (d !== 64'h0000_0002_0000_0000) begin errors++; $display("FAIL stop_rb4: got %h want 200000000", d); end
    $display("test_continuous_stop: %0d beats", cap_n);
  endtask

  task automatic test_shadow_update();
    logic [63:0] d;
    write_reg(8'd131, {16'd2, 16'd63});
    write_reg(8'd128, 32'd1);
    // seed=0, taps=05 written at beat 20 of the running burst
    collect(800, 1'b0, 20, 8'd129, {20'd0, 6'h05, 6'h00});
    build_expected(6'h3F, 6'h03, 15'h2000, 126, 63);
    checks++;
    if (timed_out || cap_n != 126) begin errors++; $display("FAIL shadow_count1: beats=%0d want 126", cap_n); end
    for (int k = 0; k < 126 && k < cap_n; k++) begin
      checks++;
      if (cap_data[k] !== exp_data[k] || cap_last[k] !== exp_last[k]) begin
        errors++;
        $display("FAIL shadow_old_beat%0d: data=%h last=%b want %h %b", k + 1, cap_data[k], cap_last[k], exp_data[k], exp_last[k]);
      end
    end
    read_reg(8'd1, d);
    checks++;
    if (d !== 64'h140) begin errors++; $display("FAIL shadow_rb1: got %h want 140", d); end
    write_reg(8'd128, 32'd1);
    collect(800, 1'b0, -1, 8'd0, 32'd0);
    build_expected(6'h01, 6'h05, 15'h2000, 126, 63);
    checks++;
    if (timed_out || cap_n != 126) begin errors++; $display("FAIL shadow_count2: beats=%0d want 126", cap_n); end
    for (int k = 0; k < 126 && k < cap_n; k++) begin
      checks++;
      if (cap_data[k] !== exp_data[k] || cap_last[k] !== exp_last[k]) begin
        errors++;
        $display("FAIL shadow_new_beat%0d: data=%h last=%b want %h %b", k + 1, cap_data[k], cap_last[k], exp_data[k], exp_last[k]);
      end
    end
    checks++;
    if (cap_data[0] !== 32'h20000000 || cap_data[1] !== 32'hE0000000 || cap_data[63] !== 32'h20000000 || cap_data[64] !== 32'hE0000000) begin
      errors++;
      $display("FAIL shadow_hand: b1=%h b2=%h b64=%h b65=%h want 20000000 e0000000 20000000 e0000000", cap_data[0], cap_data[1], cap_data[63], cap_data[64]);
    end
    $display("test_shadow_update: %0d beats", cap_n);
  endtask

  task automatic test_rst_mid_burst();
    logic [63:0] d;
    int beats;
    int bad;
    rb_addr = 8'd4;
    write_reg(8'd129, {20'd0, 6'h03, 6'h3F});
    write_reg(8'd131, {16'd0, 16'd63});
    write_reg(8'd128, 32'd1);
    beats = 0;
    for (int cyc = 0; cyc < 200 && beats < 30; cyc++) begin
      @(negedge clk);
      if (axis.o_tvalid === 1'b1 && axis.o_tready) beats++;
    end
    checks++;
    if (beats != 30) begin errors++; $display("FAIL rst_reach30: beats=%0d want 30", beats); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (axis.o_tvalid !== 1'b0 || axis.o_tlast !== 1'b0 || axis.o_tdata !== 32'd0 || rb_data !== 64'd0) begin
      errors++;
      $display("FAIL rst_outputs: valid=%b last=%b data=%h rb=%h want 0", axis.o_tvalid, axis.o_tlast, axis.o_tdata, rb_data);
    end
    rst = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (axis.o_tvalid !== 1'b0 || axis.o_tlast !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_quiet: active_cycles=%0d want 0", bad); end
    read_reg(8'd0, d);
    checks++;
    if (d !== 64'd0) begin errors++; $display("FAIL rst_rb0: got %h want 0", d); end
    read_reg(8'd3, d);
    checks++;
    if (d !== 64'd63) begin errors++; $display("FAIL rst_rb3: got %h want 3f", d); end
    read_reg(8'd2, d);
    checks++;
    if (d !== 64'h2000) begin errors++; $display("FAIL rst_rb2: got %h want 2000", d); end
    $display("test_rst_mid_burst done");
  endtask

  initial begin
    axis.o_tready = 1'b1;
    test_reset();
    test_single_period();
    test_multi_burst();
    test_backpressure();
    test_continuous_stop();
    test_shadow_update();
    test_rst_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
